// File: rtl/pi_shift_regs.sv
// Pi-side serial port: shifts Pi bytes into the RD/RC holding registers and
// serialises TD/TC back out. Optional short-frame rejection via PI_FRAME_ERR_EN.
module pi_shift_regs #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pi_sclk,
   input  logic             pi_sdata,
   input  logic             pi_le,
   input  logic [1:0]       pi_sel,
   input  logic [WIDTH-1:0] td,
   input  logic [WIDTH-1:0] tc,
   output logic             pi_sout,
   output logic [WIDTH-1:0] rd,
   output logic [WIDTH-1:0] rc,
   output logic             rd_stb,
   output logic             rc_stb,
   output logic             frame_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

   // Bundle layout: {sel[1:0], le, sdata, sclk}, all synchronised together
   logic [SYNC_STAGES-1:0][4:0] sync_q;
   logic [4:0]       rawIn;
   logic [4:0]       synced;
   logic             sclkPrev_q;
   logic             lePrev_q;
   logic             sclkRise;
   logic             leRise;
   logic [1:0]       selSync;
   logic             sdataSync;
   logic             commitOk;

   logic [WIDTH-1:0] shiftIn_q,  shiftIn_d;
   logic [WIDTH-1:0] shiftOut_q, shiftOut_d;
   logic [CNT_W-1:0] bitCnt_q,   bitCnt_d;
   logic [WIDTH-1:0] rd_q,       rd_d;
   logic [WIDTH-1:0] rc_q,       rc_d;
   logic             rdStb_q,    rdStb_d;
   logic             rcStb_q,    rcStb_d;

   assign rawIn     = {pi_sel, pi_le, pi_sdata, pi_sclk};
   assign synced    = sync_q[SYNC_STAGES-1];
   assign sdataSync = synced[1];
   assign selSync   = synced[4:3];
   assign sclkRise  = synced[0] & ~sclkPrev_q;
   assign leRise    = synced[2] & ~lePrev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         sclkPrev_q <= 1'b0;
         lePrev_q   <= 1'b0;
      end else begin
         sync_q[0] <= rawIn;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         sclkPrev_q <= synced[0];
         lePrev_q   <= synced[2];
      end
   end

`ifdef PI_FRAME_ERR_EN
   logic frameErr_q, frameErr_d;

   assign commitOk   = (bitCnt_q == FULL_CNT);
   assign frameErr_d = frameErr_q | (leRise & ~selSync[1] & ~commitOk);
   assign frame_err  = frameErr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         frameErr_q <= 1'b0;
      end else begin
         frameErr_q <= frameErr_d;
      end
   end
`else
   assign commitOk  = 1'b1;
   assign frame_err = 1'b0;
`endif

   // A latch-enable rise takes priority; a coincident sclk bit is dropped
   always_comb begin
      shiftIn_d  = shiftIn_q;
      shiftOut_d = shiftOut_q;
      bitCnt_d   = bitCnt_q;
      rd_d       = rd_q;
      rc_d       = rc_q;
      rdStb_d    = 1'b0;
      rcStb_d    = 1'b0;
      if (leRise) begin
         case (selSync)
            2'b00: begin
               if (commitOk) begin
                  rd_d    = shiftIn_q;
                  rdStb_d = 1'b1;
               end
            end
            2'b01: begin
               if (commitOk) begin
                  rc_d    = shiftIn_q;
                  rcStb_d = 1'b1;
               end
            end
            2'b10:   shiftOut_d = td;
            default: shiftOut_d = tc;
         endcase
         bitCnt_d = '0;
      end else if (sclkRise) begin
         shiftIn_d  = {shiftIn_q[WIDTH-2:0], sdataSync};
         shiftOut_d = {shiftOut_q[WIDTH-2:0], 1'b0};
         if (bitCnt_q != FULL_CNT) begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shiftIn_q  <= '0;
         shiftOut_q <= '0;
         bitCnt_q   <= '0;
         rd_q       <= '0;
         rc_q       <= '0;
         rdStb_q    <= 1'b0;
         rcStb_q    <= 1'b0;
      end else begin
         shiftIn_q  <= shiftIn_d;
         shiftOut_q <= shiftOut_d;
         bitCnt_q   <= bitCnt_d;
         rd_q       <= rd_d;
         rc_q       <= rc_d;
         rdStb_q    <= rdStb_d;
         rcStb_q    <= rcStb_d;
      end
   end

   assign pi_sout = shiftOut_q[WIDTH-1];
   assign rd      = rd_q;
   assign rc      = rc_q;
   assign rd_stb  = rdStb_q;
   assign rc_stb  = rcStb_q;

endmodule

// File: tb/tb_pi_shift_regs.sv
// Directed bench for pi_shift_regs: drives the Pi serial port slowly enough for
// the synchronisers and checks the holding registers, strobes and readback.
module tb_pi_shift_regs;

   logic       clk;
   logic       reset;
   logic       pi_sclk;
   logic       pi_sdata;
   logic       pi_le;
   logic [1:0] pi_sel;
   logic [7:0] td;
   logic [7:0] tc;
   logic       pi_sout;
   logic [7:0] rd;
   logic [7:0] rc;
   logic       rd_stb;
   logic       rc_stb;
   logic       frame_err;

   int total;
   int bad;
   int rdStbCnt;
   int rcStbCnt;
   int rdBase;
   int rcBase;

   pi_shift_regs #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .pi_sclk   (pi_sclk),
      .pi_sdata  (pi_sdata),
      .pi_le     (pi_le),
      .pi_sel    (pi_sel),
      .td        (td),
      .tc        (tc),
      .pi_sout   (pi_sout),
      .rd        (rd),
      .rc        (rc),
      .rd_stb    (rd_stb),
      .rc_stb    (rc_stb),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobes are a full clock wide, so each pulse is seen at exactly one falling edge
   initial begin
      rdStbCnt = 0;
      rcStbCnt = 0;
      forever begin
         @(negedge clk);
         if (rd_stb) rdStbCnt++;
         if (rc_stb) rcStbCnt++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic sclk, input logic sdata, input logic le,
                                input logic [1:0] sel, input int holdClks);
      pi_sclk  = sclk;
      pi_sdata = sdata;
      pi_le    = le;
      pi_sel   = sel;
      waitClk(holdClks);
   endtask

   task automatic sendBit(input logic b);
      applyStimulus(1'b0, b, 1'b0, pi_sel, 1);
      applyStimulus(1'b1, b, 1'b0, pi_sel, 5);
      applyStimulus(1'b0, b, 1'b0, pi_sel, 5);
   endtask

   task automatic sendByte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) sendBit(v[i]);
   endtask

   task automatic pulseLe(input logic [1:0] sel);
      applyStimulus(1'b0, 1'b0, 1'b0, sel, 4);
      applyStimulus(1'b0, 1'b0, 1'b1, sel, 5);
      applyStimulus(1'b0, 1'b0, 1'b0, sel, 5);
   endtask

   initial begin
      logic [7:0] expByte;
      logic [9:0] longBits;
      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      pi_sclk  = 1'b0;
      pi_sdata = 1'b0;
      pi_le    = 1'b0;
      pi_sel   = 2'b00;
      td       = 8'h00;
      tc       = 8'h00;
      waitClk(3);
      reset = 1'b0;
      waitClk(1);

      $display("[TB] reset state");
      checkOutput("reset_rd", 32'(rd), 32'h00);
      checkOutput("reset_rc", 32'(rc), 32'h00);
      checkOutput("reset_sout", 32'(pi_sout), 32'h0);
      checkOutput("reset_stb", 32'({rd_stb, rc_stb}), 32'h0);
      checkOutput("reset_ferr", 32'(frame_err), 32'h0);

      $display("[TB] commit A5 to RD with latency check");
      sendByte(8'hA5);
      rdBase = rdStbCnt;
      rcBase = rcStbCnt;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 4);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2);
      checkOutput("rd_before_latency", 32'(rd), 32'h00);
      waitClk(1);
      checkOutput("rd_at_latency", 32'(rd), 32'hA5);
      checkOutput("rd_stb_high", 32'(rd_stb), 32'h1);
      waitClk(1);
      checkOutput("rd_stb_low", 32'(rd_stb), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 5);
      checkOutput("rd_stb_count", 32'(rdStbCnt - rdBase), 32'd1);
      checkOutput("rc_after_rd", 32'(rc), 32'h00);

      $display("[TB] commit 3C to RC");
      sendByte(8'h3C);
      rdBase = rdStbCnt;
      rcBase = rcStbCnt;
      pulseLe(2'b01);
      checkOutput("rc_value", 32'(rc), 32'h3C);
      checkOutput("rd_kept", 32'(rd), 32'hA5);
      checkOutput("rc_stb_count", 32'(rcStbCnt - rcBase), 32'd1);
      checkOutput("rd_stb_none", 32'(rdStbCnt - rdBase), 32'd0);

      $display("[TB] read back TD=DD");
      td = 8'hDD;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 4);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 2);
      checkOutput("sout_before_load", 32'(pi_sout), 32'h0);
      waitClk(1);
      checkOutput("sout_at_load", 32'(pi_sout), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 5);
      td = 8'h00;
      expByte = 8'hDD;
      for (int i = 7; i >= 0; i--) begin
         checkOutput($sformatf("td_bit%0d", i), 32'(pi_sout), 32'(expByte[i]));
         sendBit(1'b0);
      end
      checkOutput("td_drained", 32'(pi_sout), 32'h0);

      $display("[TB] read back TC=CC");
      tc = 8'hCC;
      pulseLe(2'b11);
      tc = 8'h00;
      expByte = 8'hCC;
      for (int i = 7; i >= 0; i--) begin
         checkOutput($sformatf("tc_bit%0d", i), 32'(pi_sout), 32'(expByte[i]));
         sendBit(1'b0);
      end
      checkOutput("tc_drained", 32'(pi_sout), 32'h0);
      checkOutput("rd_after_loads", 32'(rd), 32'hA5);

      $display("[TB] ten-bit frame keeps last eight");
      longBits = 10'b11_0000_1111;
      for (int i = 9; i >= 0; i--) sendBit(longBits[i]);
      pulseLe(2'b00);
      checkOutput("rd_overlong", 32'(rd), 32'h0F);

      $display("[TB] five-bit short frame");
      rdBase = rdStbCnt;
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b1);
      sendBit(1'b0);
      pulseLe(2'b00);
`ifdef PI_FRAME_ERR_EN
      checkOutput("rd_short_rejected", 32'(rd), 32'h0F);
      checkOutput("short_stb", 32'(rdStbCnt - rdBase), 32'd0);
      checkOutput("ferr_set", 32'(frame_err), 32'h1);
      sendByte(8'h11);
      pulseLe(2'b00);
      checkOutput("ferr_sticky", 32'(frame_err), 32'h1);
      checkOutput("rd_after_good", 32'(rd), 32'h11);
`else
      checkOutput("rd_short_commit", 32'(rd), 32'hF6);
      checkOutput("short_stb", 32'(rdStbCnt - rdBase), 32'd1);
      checkOutput("ferr_zero", 32'(frame_err), 32'h0);
`endif

      $display("[TB] reset mid-frame");
      sendBit(1'b1);
      sendBit(1'b1);
      sendBit(1'b1);
      sendBit(1'b1);
      reset = 1'b1;
      waitClk(3);
      reset = 1'b0;
      waitClk(2);
      checkOutput("rd_after_reset", 32'(rd), 32'h00);
      checkOutput("ferr_after_reset", 32'(frame_err), 32'h0);
      sendByte(8'h81);
      pulseLe(2'b00);
      checkOutput("rd_after_midreset", 32'(rd), 32'h81);

      $display("[TB] coincident sclk and le");
      sendByte(8'h5A);
      rdBase = rdStbCnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 5);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 5);
      checkOutput("rd_coincident", 32'(rd), 32'h5A);
      checkOutput("coincident_stb", 32'(rdStbCnt - rdBase), 32'd1);
      checkOutput("bitcnt_coincident", 32'(dut.bitCnt_q), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
